// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Package    : score_pkg
// Purpose    : Shared types and constants for the score event scheduler:
//              FSM state encoding, event class codes (their numeric order is
//              also the arbitration priority), BCD digit indices and the
//              per-class (digit index, amount) pair loaded on a grant.
// Revision   : 1.0 - initial release
// ============================================================================
package score_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ADD  = 1'b1
   } state_e;

   // Lower code = higher priority.
   typedef enum logic [1:0] {
      KILL_B = 2'd0,
      KILL_E = 2'd1,
      HIT_B  = 2'd2,
      HIT_E  = 2'd3
   } ev_cls_e;

   localparam int NUM_CLS = 4;

   localparam logic [1:0] ONES = 2'd0;
   localparam logic [1:0] TENS = 2'd1;
   localparam logic [1:0] HUND = 2'd2;
   localparam logic [1:0] THOU = 2'd3;

   localparam logic [1:0] IDX_KILL_B = THOU;
   localparam logic [1:0] IDX_KILL_E = HUND;
   localparam logic [1:0] IDX_HIT_B  = ONES;
   localparam logic [1:0] IDX_HIT_E  = ONES;

   localparam logic [1:0] AMT_KILL_B = 2'd1;
   localparam logic [1:0] AMT_KILL_E = 2'd1;
   localparam logic [1:0] AMT_HIT_B  = 2'd2;
   localparam logic [1:0] AMT_HIT_E  = 2'd1;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [1:0] cls_idx(input ev_cls_e c);
      case (c)
         KILL_B:  cls_idx = IDX_KILL_B;
         KILL_E:  cls_idx = IDX_KILL_E;
         HIT_B:   cls_idx = IDX_HIT_B;
         default: cls_idx = IDX_HIT_E;
      endcase
   endfunction

   function automatic logic [1:0] cls_amt(input ev_cls_e c);
      case (c)
         KILL_B:  cls_amt = AMT_KILL_B;
         KILL_E:  cls_amt = AMT_KILL_E;
         HIT_B:   cls_amt = AMT_HIT_B;
         default: cls_amt = AMT_HIT_E;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pend_counter.sv
`default_nettype none
// ============================================================================
// Module     : pend_counter
// Purpose    : Saturating pending-event counter. Adds 0..4 arrivals and
//              subtracts one grant per cycle; clamps at 2^W-1 and flags any
//              arrival lost to the clamp.
// Ports      : clk_i   - clock
//              rst_ni  - asynchronous active-low reset
//              clr_i   - synchronous clear (discards same-cycle arrivals)
//              arr_i   - number of arrivals this cycle (0..4)
//              dec_i   - grant: consume one pending event
//              cnt_o   - current count
//              ovf_o   - combinational: an arrival is being dropped this cycle
// Revision   : 1.0 - initial release
// ============================================================================
module pend_counter #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic [2:0]   arr_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         ovf_o
);

   // Wide enough to hold max count + 4 without wrapping.
   localparam int            SW  = W + 3;
   localparam logic [SW-1:0] MAX = SW'((1 << W) - 1);

   logic [W-1:0]  cnt_q, cnt_d;
   logic [SW-1:0] nxt;

   always_comb begin
      nxt   = SW'(cnt_q) + SW'(arr_i) - SW'(dec_i);
      cnt_d = cnt_q;
      ovf_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (nxt > MAX) begin
         cnt_d = MAX[W-1:0];
         ovf_o = 1'b1;
      end else begin
         cnt_d = nxt[W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/score_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : score_event_scheduler
// Purpose    : Collects hit/kill scoring events into per-class pending
//              counters, grants them one at a time by fixed priority and adds
//              them into a 4-digit BCD score, rippling carries one digit per
//              cycle and saturating at 9999.
// Ports      : clk22          - game clock
//              rst_n          - asynchronous active-low reset
//              gamestart      - clear; also disarms kill detectors
//              shot_reimu     - player hit; clears score
//              shot_enm       - enemy hit pulse (+1)
//              shot_boss      - boss hit pulse (+2)
//              enmhp1..4      - enemy HP (kill on nonzero -> zero)
//              bosshp         - boss HP (kill on nonzero -> zero, +1000)
//              score0..3      - BCD digits, ones .. thousands
//              busy           - FSM active or events pending
//              pend_ovf       - sticky: an event was dropped
// Revision   : 1.0 - initial release
// ============================================================================
module score_event_scheduler
   import score_pkg::*;
#(
   parameter int PEND_W    = 3,
   parameter int ENM_HP_W  = 7,
   parameter int BOSS_HP_W = 10
) (
   input  logic                 clk22,
   input  logic                 rst_n,
   input  logic                 gamestart,
   input  logic                 shot_reimu,
   input  logic                 shot_enm,
   input  logic                 shot_boss,
   input  logic [ENM_HP_W-1:0]  enmhp1,
   input  logic [ENM_HP_W-1:0]  enmhp2,
   input  logic [ENM_HP_W-1:0]  enmhp3,
   input  logic [ENM_HP_W-1:0]  enmhp4,
   input  logic [BOSS_HP_W-1:0] bosshp,
   output logic [3:0]           score0,
   output logic [3:0]           score1,
   output logic [3:0]           score2,
   output logic [3:0]           score3,
   output logic                 busy,
   output logic                 pend_ovf
);

   state_e              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [1:0]          amt_q, amt_d;
   logic [3:0][3:0]     digit_q, digit_d;
   logic                pend_ovf_q;
   logic [3:0]          alive_e_q;
   logic                alive_b_q;

   logic                clr;
   logic [3:0]          enm_alive_now;
   logic [3:0]          kill_e;
   logic                kill_b;
   logic [2:0]          arr      [NUM_CLS];
   logic [PEND_W-1:0]   pend_cnt [NUM_CLS];
   logic [NUM_CLS-1:0]  grant;
   logic [NUM_CLS-1:0]  ovf;
   logic                any_pend;
   ev_cls_e             sel;
   logic [4:0]          sum;

   assign clr           = gamestart | shot_reimu;
   assign enm_alive_now = {enmhp4 != '0, enmhp3 != '0, enmhp2 != '0, enmhp1 != '0};

   // A kill is a was-alive flag meeting zero HP; HP that is already zero
   // after reset/gamestart never had its flag set, so it never scores.
   assign kill_e = alive_e_q & ~enm_alive_now;
   assign kill_b = alive_b_q & (bosshp == '0);

   always_comb begin
      arr[KILL_B] = {2'b00, kill_b};
      arr[KILL_E] = {2'b00, kill_e[0]} + {2'b00, kill_e[1]}
                  + {2'b00, kill_e[2]} + {2'b00, kill_e[3]};
      arr[HIT_B]  = {2'b00, shot_boss};
      arr[HIT_E]  = {2'b00, shot_enm};
   end

   for (genvar c = 0; c < NUM_CLS; c++) begin : g_pend
      pend_counter #(.W(PEND_W)) u_cnt (
         .clk_i  (clk22),
         .rst_ni (rst_n),
         .clr_i  (clr),
         .arr_i  (arr[c]),
         .dec_i  (grant[c]),
         .cnt_o  (pend_cnt[c]),
         .ovf_o  (ovf[c])
      );
   end

   // Fixed-priority select among nonzero counters.
   always_comb begin
      sel      = HIT_E;
      any_pend = 1'b1;
      if      (pend_cnt[KILL_B] != '0) sel = KILL_B;
      else if (pend_cnt[KILL_E] != '0) sel = KILL_E;
      else if (pend_cnt[HIT_B]  != '0) sel = HIT_B;
      else if (pend_cnt[HIT_E]  != '0) sel = HIT_E;
      else                             any_pend = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      amt_d   = amt_q;
      digit_d = digit_q;
      grant   = '0;
      sum     = {1'b0, digit_q[idx_q]} + {3'b000, amt_q};
      if (clr) begin
         state_d = IDLE;
         idx_d   = ONES;
         amt_d   = '0;
         digit_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_pend) begin
                  grant[sel] = 1'b1;
                  idx_d      = cls_idx(sel);
                  amt_d      = cls_amt(sel);
                  state_d    = ADD;
               end
            end
            ADD: begin
               if (sum <= {1'b0, BCD_MAX}) begin
                  digit_d[idx_q] = sum[3:0];
                  state_d        = IDLE;
               end else if (idx_q != THOU) begin
                  // sum is 10 or 11 here, so the 4-bit subtract cannot wrap.
                  digit_d[idx_q] = sum[3:0] - 4'd10;
                  idx_d          = idx_q + 2'd1;
                  amt_d          = 2'd1;
               end else begin
                  digit_d = {4{BCD_MAX}};
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk22 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= ONES;
         amt_q      <= '0;
         digit_q    <= '0;
         pend_ovf_q <= 1'b0;
         alive_e_q  <= '0;
         alive_b_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         amt_q      <= amt_d;
         digit_q    <= digit_d;
         pend_ovf_q <= clr ? 1'b0 : (pend_ovf_q | (|ovf));
         alive_e_q  <= gamestart ? 4'b0000 : enm_alive_now;
         alive_b_q  <= ~gamestart & (bosshp != '0);
      end
   end

   assign score0   = digit_q[ONES];
   assign score1   = digit_q[TENS];
   assign score2   = digit_q[HUND];
   assign score3   = digit_q[THOU];
   assign pend_ovf = pend_ovf_q;
   assign busy     = (state_q != IDLE)
                   | (pend_cnt[KILL_B] != '0) | (pend_cnt[KILL_E] != '0)
                   | (pend_cnt[HIT_B]  != '0) | (pend_cnt[HIT_E]  != '0);

endmodule
`default_nettype wire

// File: tb/tb_score_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_score_event_scheduler
// Purpose    : Self-checking bench for score_event_scheduler. A behavioural
//              model tracks score digits, pending event counts and the
//              carry in progress; a negedge process compares every cycle.
//              Directed scenarios add literal expectations, followed by a
//              randomized run.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_score_event_scheduler;

   localparam int PEND_W   = 3;
   localparam int PEND_MAX = (1 << PEND_W) - 1;

   logic       clk22 = 1'b0;
   logic       rst_n = 1'b0;
   logic       gamestart = 1'b0, shot_reimu = 1'b0, shot_enm = 1'b0, shot_boss = 1'b0;
   logic [6:0] enmhp1 = '0, enmhp2 = '0, enmhp3 = '0, enmhp4 = '0;
   logic [9:0] bosshp = '0;
   logic [3:0] score0, score1, score2, score3;
   logic       busy, pend_ovf;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   score_event_scheduler #(.PEND_W(PEND_W), .ENM_HP_W(7), .BOSS_HP_W(10)) dut (
      .clk22      (clk22),
      .rst_n      (rst_n),
      .gamestart  (gamestart),
      .shot_reimu (shot_reimu),
      .shot_enm   (shot_enm),
      .shot_boss  (shot_boss),
      .enmhp1     (enmhp1),
      .enmhp2     (enmhp2),
      .enmhp3     (enmhp3),
      .enmhp4     (enmhp4),
      .bosshp     (bosshp),
      .score0     (score0),
      .score1     (score1),
      .score2     (score2),
      .score3     (score3),
      .busy       (busy),
      .pend_ovf   (pend_ovf)
   );

   always #5 clk22 = ~clk22;

   // ---------------- behavioural model ----------------
   // Classes: 0 boss kill, 1 enemy kill, 2 boss hit, 3 enemy hit (priority order).
   int m_dig  [4];
   int m_pend [4];
   bit m_add;
   int m_idx, m_amt;
   bit m_ovf;
   bit m_ae [4];
   bit m_ab;

   function automatic logic [15:0] model_score();
      logic [15:0] s;
      for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'(m_dig[i]);
      return s;
   endfunction

   function automatic bit model_busy();
      return m_add || (m_pend[0] + m_pend[1] + m_pend[2] + m_pend[3]) > 0;
   endfunction

   always @(posedge clk22 or negedge rst_n) begin
      int arr [4];
      int hp  [4];
      int g, s, v;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_dig[i] = 0; m_pend[i] = 0; m_ae[i] = 0;
         end
         m_add = 0; m_idx = 0; m_amt = 0; m_ovf = 0; m_ab = 0;
      end else begin
         hp[0] = int'(enmhp1); hp[1] = int'(enmhp2); hp[2] = int'(enmhp3); hp[3] = int'(enmhp4);
         arr[0] = (m_ab && bosshp == 0) ? 1 : 0;
         arr[1] = 0;
         for (int i = 0; i < 4; i++) if (m_ae[i] && hp[i] == 0) arr[1]++;
         arr[2] = shot_boss ? 1 : 0;
         arr[3] = shot_enm ? 1 : 0;
         if (gamestart || shot_reimu) begin
            for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_pend[i] = 0; end
            m_add = 0; m_ovf = 0;
         end else begin
            g = -1;
            if (!m_add) begin
               for (int c = 0; c < 4; c++) if (g < 0 && m_pend[c] > 0) g = c;
               if (g >= 0) begin
                  m_add = 1;
                  m_idx = (g == 0) ? 3 : (g == 1) ? 2 : 0;
                  m_amt = (g == 2) ? 2 : 1;
               end
            end else begin
               s = m_dig[m_idx] + m_amt;
               if (s <= 9) begin
                  m_dig[m_idx] = s; m_add = 0;
               end else if (m_idx < 3) begin
                  m_dig[m_idx] = s - 10; m_idx++; m_amt = 1;
               end else begin
                  for (int i = 0; i < 4; i++) m_dig[i] = 9;
                  m_add = 0;
               end
            end
            for (int c = 0; c < 4; c++) begin
               v = m_pend[c] + arr[c] - ((g == c) ? 1 : 0);
               if (v > PEND_MAX) begin v = PEND_MAX; m_ovf = 1; end
               m_pend[c] = v;
            end
         end
         for (int i = 0; i < 4; i++) m_ae[i] = !gamestart && hp[i] != 0;
         m_ab = !gamestart && bosshp != 0;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_score();
      return {score3, score2, score1, score0};
   endfunction

   always @(negedge clk22) begin
      if (chk_en) begin
         chk("score", 32'(dut_score()), 32'(model_score()));
         chk("busy", 32'(busy), 32'(model_busy()));
         chk("pend_ovf", 32'(pend_ovf), 32'(m_ovf));
         chk("digit_range", 32'(score0 <= 9 && score1 <= 9 && score2 <= 9 && score3 <= 9), 32'd1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk22);
   endtask

   task automatic pulse(input bit e, input bit b, input bit r, input bit gs);
      shot_enm = e; shot_boss = b; shot_reimu = r; gamestart = gs;
      tick();
      shot_enm = 0; shot_boss = 0; shot_reimu = 0; gamestart = 0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy === 1'b1 && n < budget) begin tick(); n++; end
      if (busy !== 1'b0) begin
         total++; bad++;
         $display("FAIL wait_idle: busy=%b after %0d cycles", busy, budget);
      end
   endtask

   task automatic boss_hits(input int n);
      for (int i = 0; i < n; i++) begin pulse(0, 1, 0, 0); wait_idle(20); end
   endtask

   task automatic kill_enemies(input int k);
      enmhp1 = (k > 0) ? 7'd5 : 7'd0; enmhp2 = (k > 1) ? 7'd5 : 7'd0;
      enmhp3 = (k > 2) ? 7'd5 : 7'd0; enmhp4 = (k > 3) ? 7'd5 : 7'd0;
      tick();
      enmhp1 = 0; enmhp2 = 0; enmhp3 = 0; enmhp4 = 0;
      tick();
      wait_idle(40);
   endtask

   task automatic kill_boss();
      bosshp = 10'd300;
      tick();
      bosshp = 0;
      tick();
      wait_idle(20);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      tick(); tick();
      chk("reset_score", 32'(dut_score()), 32'h0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ovf", 32'(pend_ovf), 32'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // 1: single enemy hit, busy for exactly two cycles
      pulse(1, 0, 0, 0);
      chk("t1_busy_e1", 32'(busy), 32'd1);
      tick();
      chk("t1_busy_e2", 32'(busy), 32'd1);
      tick();
      chk("t1_busy_e3", 32'(busy), 32'd0);
      chk("t1_score", 32'(dut_score()), 32'h0001);

      // 2: 0098 + boss hit ripples to 0100
      pulse(0, 0, 1, 0);
      boss_hits(49);
      chk("t2_pre", 32'(dut_score()), 32'h0098);
      pulse(0, 1, 0, 0);
      wait_idle(20);
      chk("t2_score", 32'(dut_score()), 32'h0100);

      // 3: four simultaneous kills plus a hit
      pulse(0, 0, 1, 0);
      enmhp1 = 5; enmhp2 = 5; enmhp3 = 5; enmhp4 = 5;
      tick();
      enmhp1 = 0; enmhp2 = 0; enmhp3 = 0; enmhp4 = 0; shot_enm = 1;
      tick();
      shot_enm = 0;
      wait_idle(40);
      chk("t3_score", 32'(dut_score()), 32'h0401);

      // 4: saturation at 9999
      pulse(0, 0, 1, 0);
      for (int i = 0; i < 9; i++) kill_boss();
      kill_enemies(4); kill_enemies(4); kill_enemies(1);
      boss_hits(49);
      chk("t4_pre", 32'(dut_score()), 32'h9998);
      kill_boss();
      chk("t4_sat", 32'(dut_score()), 32'h9999);
      pulse(1, 0, 0, 0);
      wait_idle(20);
      chk("t4_hold", 32'(dut_score()), 32'h9999);

      // 5: enemy hits starved by boss hits overflow their counter
      pulse(0, 0, 1, 0);
      shot_enm = 1; shot_boss = 1;
      repeat (8) tick();
      shot_enm = 0; shot_boss = 0;
      chk("t5_ovf", 32'(pend_ovf), 32'd1);
      wait_idle(100);
      chk("t5_score", 32'(dut_score()), 32'h0023);
      pulse(0, 0, 1, 0);
      chk("t5_clr_score", 32'(dut_score()), 32'h0);
      chk("t5_clr_ovf", 32'(pend_ovf), 32'd0);

      // 6: boss dying during gamestart never scores; later kill does
      bosshp = 10'd300;
      tick();
      bosshp = 0; gamestart = 1;
      tick();
      gamestart = 0;
      repeat (6) tick();
      chk("t6_nokill", 32'(dut_score()), 32'h0);
      kill_boss();
      chk("t6_kill", 32'(dut_score()), 32'h1000);

      // 6b: clear in the middle of a carry ripple
      pulse(0, 0, 1, 0);
      kill_enemies(4); kill_enemies(4); kill_enemies(1);
      boss_hits(49);
      pulse(1, 0, 0, 0);
      wait_idle(20);
      chk("t6_pre", 32'(dut_score()), 32'h0999);
      pulse(1, 0, 0, 0);
      tick();
      tick();
      chk("t6_mid", 32'(dut_score()), 32'h0990);
      pulse(0, 0, 1, 0);
      chk("t6_abort_score", 32'(dut_score()), 32'h0);
      chk("t6_abort_busy", 32'(busy), 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         shot_enm   = ($urandom_range(0, 3) == 0);
         shot_boss  = ($urandom_range(0, 3) == 0);
         shot_reimu = ($urandom_range(0, 63) == 0);
         gamestart  = ($urandom_range(0, 127) == 0);
         if ($urandom_range(0, 5) == 0) enmhp1 = $urandom_range(0, 1) ? 7'd0 : 7'($urandom_range(1, 127));
         if ($urandom_range(0, 5) == 0) enmhp2 = $urandom_range(0, 1) ? 7'd0 : 7'($urandom_range(1, 127));
         if ($urandom_range(0, 5) == 0) enmhp3 = $urandom_range(0, 1) ? 7'd0 : 7'($urandom_range(1, 127));
         if ($urandom_range(0, 5) == 0) enmhp4 = $urandom_range(0, 1) ? 7'd0 : 7'($urandom_range(1, 127));
         if ($urandom_range(0, 7) == 0) bosshp = $urandom_range(0, 1) ? 10'd0 : 10'($urandom_range(1, 1023));
         if (n == 1500) begin
            #2 rst_n = 1'b0;
            tick();
            chk("async_reset_score", 32'(dut_score()), 32'h0);
            chk("async_reset_busy", 32'(busy), 32'd0);
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      shot_enm = 0; shot_boss = 0; shot_reimu = 0; gamestart = 0;
      wait_idle(200);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
